// File: rtl/vga_pkg.sv
// Shared geometry and swap-controller state encoding for the VGA frame-buffer path.
package vga_pkg;

  localparam int unsigned H_DISP   = 640;
  localparam int unsigned V_DISP   = 480;
  localparam int unsigned FB_WORDS = H_DISP * V_DISP;

  typedef enum logic {
    IDLE,
    PENDING
  } swap_state_t;

endpackage

// File: rtl/vga_fb_swap_ctrl.sv
// Frame-start detection and front/back buffer flip control.
// FB_DOUBLE_BUF_EN selects real buffer flipping; otherwise swap_done is a plain frame tick.
module vga_fb_swap_ctrl
  import vga_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic vs,
  input  logic swap_req,
  output logic front_sel,
  output logic swap_done
);

  logic vs_q;
  logic frame_start;
  logic flip;
  logic flip_q;

  assign frame_start = vs_q & ~vs;

`ifdef FB_DOUBLE_BUF_EN
  swap_state_t state, state_nxt;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // swap_req arriving while PENDING is dropped; one coinciding with frame start in IDLE waits a frame
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (swap_req)    state_nxt = PENDING;
      PENDING: if (frame_start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    flip = (state == PENDING) && frame_start;
  end

  always_ff @(posedge clk) begin
    if (!rst)      front_sel <= 1'b0;
    else if (flip) front_sel <= ~front_sel;
  end
`else
  logic unused_swap_req;
  assign unused_swap_req = swap_req;
  assign flip      = frame_start;
  assign front_sel = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      vs_q      <= 1'b1;
      flip_q    <= 1'b0;
      swap_done <= 1'b0;
    end else begin
      vs_q      <= vs;
      flip_q    <= flip;
      swap_done <= flip_q;
    end
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: display reads have absolute priority, writer gets idle cycles.
// Double buffering is enabled with FB_DOUBLE_BUF_EN.
module vga_fb_arbiter #(
  parameter int unsigned H_DISP = vga_pkg::H_DISP,
  parameter int unsigned V_DISP = vga_pkg::V_DISP,
  parameter int unsigned AW     = 20,
  parameter int unsigned DW     = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [9:0]    pixel_x,
  input  logic [9:0]    pixel_y,
  input  logic          vs,
  output logic [DW-1:0] pixel_data,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          swap_req,
  output logic          swap_done,
  output logic          front_sel,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [15:0]   stall_cnt,
  output logic [15:0]   err_cnt
);

  localparam logic [AW-1:0] FB_W = AW'(H_DISP * V_DISP);

  logic          disp_req;
  logic          wr_acc;
  logic          wr_in_range;
  logic          rd_q;
  logic [AW-1:0] front_base;
  logic [AW-1:0] back_base;
  logic [AW-1:0] x_m1;
  logic [AW-1:0] y_m1;

  vga_fb_swap_ctrl u_swap (
    .clk       (clk),
    .rst       (rst),
    .vs        (vs),
    .swap_req  (swap_req),
    .front_sel (front_sel),
    .swap_done (swap_done)
  );

`ifdef FB_DOUBLE_BUF_EN
  assign front_base = front_sel ? FB_W : '0;
  assign back_base  = front_sel ? '0 : FB_W;
`else
  assign front_base = '0;
  assign back_base  = '0;
`endif

  assign disp_req    = (pixel_x != 10'd0);
  assign wr_ready    = ~disp_req;
  assign wr_acc      = wr_valid & wr_ready;
  assign wr_in_range = (wr_addr < FB_W);
  assign x_m1        = AW'(pixel_x) - AW'(1);
  assign y_m1        = AW'(pixel_y) - AW'(1);

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (disp_req) begin
      mem_en   = 1'b1;
      mem_addr = front_base + y_m1 * AW'(H_DISP) + x_m1;
    end else if (wr_acc && wr_in_range) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = back_base + wr_addr;
      mem_wdata = wr_data;
    end
  end

  assign pixel_data = rd_q ? mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_q      <= 1'b0;
      stall_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      rd_q <= disp_req;
      if (wr_valid && !wr_ready && stall_cnt != '1)
        stall_cnt <= stall_cnt + 16'd1;
      if (wr_acc && !wr_in_range && err_cnt != '1)
        err_cnt <= err_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed self-checking bench for vga_fb_arbiter; expectations follow FB_DOUBLE_BUF_EN.
module tb_vga_fb_arbiter;

`ifdef FB_DOUBLE_BUF_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  pixel_x, pixel_y;
  logic        vs;
  logic [23:0] pixel_data;
  logic        wr_valid, wr_ready;
  logic [19:0] wr_addr;
  logic [23:0] wr_data;
  logic        swap_req, swap_done, front_sel;
  logic        mem_en, mem_we;
  logic [19:0] mem_addr;
  logic [23:0] mem_wdata, mem_rdata;
  logic [15:0] stall_cnt, err_cnt;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  vga_fb_arbiter #(.H_DISP(640), .V_DISP(480), .AW(20), .DW(24)) dut (
    .clk        (clk),
    .rst        (rst),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .vs         (vs),
    .pixel_data (pixel_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .swap_req   (swap_req),
    .swap_done  (swap_done),
    .front_sel  (front_sel),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .stall_cnt  (stall_cnt),
    .err_cnt    (err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and land on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; pixel_x = '0; pixel_y = '0; vs = 1'b1;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; swap_req = 1'b0; mem_rdata = '0;
    tick(); tick();
    check("rst_pixel_data", 32'(pixel_data), 32'h0);
    check("rst_front_sel",  32'(front_sel), 32'h0);
    check("rst_swap_done",  32'(swap_done), 32'h0);
    check("rst_stall_cnt",  32'(stall_cnt), 32'h0);
    check("rst_err_cnt",    32'(err_cnt), 32'h0);
    check("rst_wr_ready",   32'(wr_ready), 32'h1);
    check("rst_mem_en",     32'(mem_en), 32'h0);
    rst = 1'b1;
    tick();

    // display read at (1,1)
    pixel_x = 10'd1; pixel_y = 10'd1; #1;
    check("rd_mem_en",   32'(mem_en), 32'h1);
    check("rd_mem_we",   32'(mem_we), 32'h0);
    check("rd_mem_addr", 32'(mem_addr), 32'h0);
    check("rd_wr_ready", 32'(wr_ready), 32'h0);
    tick();
    pixel_x = '0; pixel_y = '0; mem_rdata = 24'hABCDEF; #1;
    check("rd_pixel_data", 32'(pixel_data), 32'hABCDEF);
    tick();
    check("rd_pixel_idle", 32'(pixel_data), 32'h0);
    check("idle_mem_addr", 32'(mem_addr), 32'h0);

    // accepted write into back buffer
    wr_valid = 1'b1; wr_addr = 20'd5; wr_data = 24'h123456; #1;
    check("wr_ready",     32'(wr_ready), 32'h1);
    check("wr_mem_we",    32'(mem_we), 32'h1);
    check("wr_mem_addr",  32'(mem_addr), DB ? 32'd307205 : 32'd5);
    check("wr_mem_wdata", 32'(mem_wdata), 32'h123456);
    tick();
    wr_valid = 1'b0;

    // writer stalled behind display for three cycles
    pixel_x = 10'd10; pixel_y = 10'd2; wr_valid = 1'b1; #1;
    check("stall_wr_ready",  32'(wr_ready), 32'h0);
    check("stall_mem_we",    32'(mem_we), 32'h0);
    check("stall_mem_addr",  32'(mem_addr), 32'd649);
    tick(); tick(); tick();
    pixel_x = '0; pixel_y = '0; wr_valid = 1'b0; #1;
    check("stall_cnt", 32'(stall_cnt), 32'd3);

    // out-of-range write is consumed with no RAM access
    wr_valid = 1'b1; wr_addr = 20'd307200; #1;
    check("oor_wr_ready", 32'(wr_ready), 32'h1);
    check("oor_mem_en",   32'(mem_en), 32'h0);
    tick();
    check("oor_err_cnt",  32'(err_cnt), 32'd1);
    wr_addr = 20'd307199; #1;
    check("last_mem_addr", 32'(mem_addr), DB ? 32'd614399 : 32'd307199);
    tick();
    wr_valid = 1'b0;
    check("last_err_cnt", 32'(err_cnt), 32'd1);

    // swap request mid-frame, flip at next vs falling edge
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    check("pend_front_sel", 32'(front_sel), 32'h0);
    vs = 1'b0;
    tick();
    check("flip_front_sel", 32'(front_sel), DB ? 32'h1 : 32'h0);
    check("flip_swap_done0", 32'(swap_done), 32'h0);
    tick();
    check("flip_swap_done1", 32'(swap_done), 32'h1);
    vs = 1'b1;
    tick();
    check("flip_swap_done2", 32'(swap_done), 32'h0);
    pixel_x = 10'd1; pixel_y = 10'd1; #1;
    check("flip_rd_addr", 32'(mem_addr), DB ? 32'd307200 : 32'd0);
    tick();
    pixel_x = '0; pixel_y = '0;
    wr_valid = 1'b1; wr_addr = 20'd5; #1;
    check("flip_wr_addr", 32'(mem_addr), 32'd5);
    tick();
    wr_valid = 1'b0;

    // reset while pending discards the swap
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("rst2_front_sel", 32'(front_sel), 32'h0);
    check("rst2_stall_cnt", 32'(stall_cnt), 32'h0);
    check("rst2_err_cnt",   32'(err_cnt), 32'h0);
    vs = 1'b0;
    tick();
    check("rst2_vs_front_sel", 32'(front_sel), 32'h0);
    tick();
    check("rst2_swap_done", 32'(swap_done), DB ? 32'h0 : 32'h1);
    vs = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
